// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Brief  : Shared RV32I pipeline constants: ALU opcodes, forward selects and
//          default datapath widths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_REG_AW = 5;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b111;

    // Select 2'b11 is not a member and falls back to the register-file operand.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

`default_nettype wire

// File: rtl/execute_stage_if.sv
// ============================================================================
// Module : execute_stage_if
// Brief  : ID/EX inputs, hazard-unit selects and EX/MEM outputs of the
//          execute stage. The slave modport is the execute stage's view.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface execute_stage_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              RegWriteE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              ALUSrcE;
    logic              BranchE;
    logic              JumpE;
    logic [2:0]        ALUControlE;
    logic [XLEN-1:0]   RD1_E;
    logic [XLEN-1:0]   RD2_E;
    logic [XLEN-1:0]   Imm_Ext_E;
    logic [REG_AW-1:0] RD_E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic [XLEN-1:0]   ResultW;
    logic              StallM;
    logic              FlushM;

    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic              ResultSrcM;
    logic [REG_AW-1:0] RD_M;
    logic [XLEN-1:0]   ALU_ResultM;
    logic [XLEN-1:0]   WriteDataM;
    logic [XLEN-1:0]   PCPlus4M;

    modport master (
        output RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW, StallM, FlushM,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE, JumpE,
               ALUControlE, RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
               ForwardA_E, ForwardB_E, ResultW, StallM, FlushM,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RD_M,
               ALU_ResultM, WriteDataM, PCPlus4M
    );
endinterface

`default_nettype wire

// File: rtl/execute_stage_alu.sv
// ============================================================================
// Module : alu
// Brief  : Combinational RV32I ALU with zero flag. Opcode 111 is a single-cycle
//          low-half signed multiply when EX_MUL_EN is defined, else yields 0.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  wire logic [XLEN-1:0] SrcA,
    input  wire logic [XLEN-1:0] SrcB,
    input  wire logic [2:0]      ALUControl,
    output logic [XLEN-1:0]      Result,
    output logic                 Zero
);

`ifdef EX_MUL_EN
    // The low half of a product is sign-agnostic; signed form kept for clarity.
    logic [XLEN-1:0] w_mul_lo;
    assign w_mul_lo = $signed(SrcA) * $signed(SrcB);
`endif

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD:  Result = SrcA + SrcB;
            ALU_SUB:  Result = SrcA - SrcB;
            ALU_AND:  Result = SrcA & SrcB;
            ALU_OR:   Result = SrcA | SrcB;
            ALU_XOR:  Result = SrcA ^ SrcB;
            ALU_SLT:  Result = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLTU: Result = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
`ifdef EX_MUL_EN
            ALU_MUL:  Result = w_mul_lo;
`endif
            default:  Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

`default_nettype wire

// File: rtl/execute_stage.sv
// ============================================================================
// Module : execute_stage
// Brief  : RV32I EX stage: operand forwarding, ALU, branch/jump resolution and
//          the EX/MEM pipeline register. Optional RV32M mul via EX_MUL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int REG_AW = DEF_REG_AW
) (
    input  wire logic       clk,
    input  wire logic       rst,
    execute_stage_if.slave  ex
);

    logic [XLEN-1:0]   w_src_a;
    logic [XLEN-1:0]   w_fwd_b;
    logic [XLEN-1:0]   w_src_b;
    logic [XLEN-1:0]   w_alu_result;
    logic              w_zero;

    logic              regwrite_q,  regwrite_d;
    logic              memwrite_q,  memwrite_d;
    logic              resultsrc_q, resultsrc_d;
    logic [REG_AW-1:0] rd_q,        rd_d;
    logic [XLEN-1:0]   alu_res_q,   alu_res_d;
    logic [XLEN-1:0]   wdata_q,     wdata_d;
    logic [XLEN-1:0]   pcp4_q,      pcp4_d;

    // The MEM-stage bypass taps our own registered result, so a held stall
    // keeps feeding the same value back.
    always_comb begin
        w_src_a = ex.RD1_E;
        case (ex.ForwardA_E)
            FWD_WB:  w_src_a = ex.ResultW;
            FWD_MEM: w_src_a = alu_res_q;
            default: w_src_a = ex.RD1_E;
        endcase
    end

    always_comb begin
        w_fwd_b = ex.RD2_E;
        case (ex.ForwardB_E)
            FWD_WB:  w_fwd_b = ex.ResultW;
            FWD_MEM: w_fwd_b = alu_res_q;
            default: w_fwd_b = ex.RD2_E;
        endcase
    end

    assign w_src_b = ex.ALUSrcE ? ex.Imm_Ext_E : w_fwd_b;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (w_src_a),
        .SrcB       (w_src_b),
        .ALUControl (ex.ALUControlE),
        .Result     (w_alu_result),
        .Zero       (w_zero)
    );

    assign ex.PCSrcE    = (ex.BranchE & w_zero) | ex.JumpE;
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

    // Flush clears only control and destination; data registers simply hold.
    always_comb begin
        regwrite_d  = regwrite_q;
        memwrite_d  = memwrite_q;
        resultsrc_d = resultsrc_q;
        rd_d        = rd_q;
        alu_res_d   = alu_res_q;
        wdata_d     = wdata_q;
        pcp4_d      = pcp4_q;
        if (ex.FlushM) begin
            regwrite_d  = 1'b0;
            memwrite_d  = 1'b0;
            resultsrc_d = 1'b0;
            rd_d        = '0;
        end else if (!ex.StallM) begin
            regwrite_d  = ex.RegWriteE;
            memwrite_d  = ex.MemWriteE;
            resultsrc_d = ex.ResultSrcE;
            rd_d        = ex.RD_E;
            alu_res_d   = w_alu_result;
            wdata_d     = w_fwd_b;
            pcp4_d      = ex.PCPlus4E;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q  <= 1'b0;
            memwrite_q  <= 1'b0;
            resultsrc_q <= 1'b0;
            rd_q        <= '0;
            alu_res_q   <= '0;
            wdata_q     <= '0;
            pcp4_q      <= '0;
        end else begin
            regwrite_q  <= regwrite_d;
            memwrite_q  <= memwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            alu_res_q   <= alu_res_d;
            wdata_q     <= wdata_d;
            pcp4_q      <= pcp4_d;
        end
    end

    assign ex.RegWriteM   = regwrite_q;
    assign ex.MemWriteM   = memwrite_q;
    assign ex.ResultSrcM  = resultsrc_q;
    assign ex.RD_M        = rd_q;
    assign ex.ALU_ResultM = alu_res_q;
    assign ex.WriteDataM  = wdata_q;
    assign ex.PCPlus4M    = pcp4_q;

endmodule

`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX operands plus the forwarding selects produced by the hazard unit. Resolves operand forwarding, computes the ALU result, resolves branch/jump redirects and computes the branch target.
- Registers the results into the EX/MEM pipeline register, which supplies RegWriteM/RD_M back to the hazard unit and data to the memory stage.

Parameters:
- XLEN, 32, datapath width in bits.
- REG_AW, 5, register-address width.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- RegWriteE  input  1  register-write enable of instruction in EX.
- MemWriteE  input  1  store enable of instruction in EX.
- ResultSrcE  input  1  writeback select (0 = ALU, 1 = memory).
- ALUSrcE  input  1  ALU operand B select (0 = forwarded rs2, 1 = immediate).
- BranchE  input  1  conditional branch (beq).
- JumpE  input  1  unconditional jump (jal).
- ALUControlE  input  3  ALU operation code.
- RD1_E, RD2_E  input  XLEN  register-file read data.
- Imm_Ext_E  input  XLEN  sign-extended immediate.
- RD_E  input  REG_AW  destination register.
- PCE, PCPlus4E  input  XLEN  instruction PC and PC+4.
- ForwardA_E, ForwardB_E  input  2  forwarding selects from the hazard unit.
- ResultW  input  XLEN  writeback-stage result.
- StallM  input  1  hold the EX/MEM register.
- FlushM  input  1  insert a bubble into EX/MEM.
- PCSrcE  output  1  redirect fetch (combinational).
- PCTargetE  output  XLEN  branch/jump target (combinational).
- RegWriteM, MemWriteM, ResultSrcM  output  1  registered control.
- RD_M  output  REG_AW  registered destination.
- ALU_ResultM, WriteDataM, PCPlus4M  output  XLEN  registered data.

Behaviour:
- Forward mux A/B:
  - 00 → RD1_E/RD2_E.
  - 01 → ResultW.
  - 10 → ALU_ResultM (internal feedback of the registered output).
  - 11 → treated as 00.
- SrcB = ALUSrcE ? Imm_Ext_E : forwarded B.
- WriteData = forwarded B, always; the immediate is never used here.
- ALUControlE codes:
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 slt (signed, result 1 or 0); 110 sltu (unsigned).
  - 111 → see Optional Feature.
- Arithmetic is modulo 2^XLEN and carries are discarded.
- Zero = (ALU result == 0).
- PCSrcE = (BranchE & Zero) | JumpE.
- PCTargetE = PCE + Imm_Ext_E, modulo 2^XLEN. Both outputs are purely combinational with zero latency.
- EX/MEM register: one-cycle latency from EX inputs to the *M outputs.
- Update priority per rising edge:
  1. FlushM: RegWriteM, MemWriteM and ResultSrcM go to 0; data regs may take any value; RD_M goes to 0. Flush wins over stall.
  2. Else StallM: all M registers hold their values.
  3. Else: load from EX.
- Reset: asynchronous on rst=1. All M outputs go to 0 immediately, regardless of clk.
- Release of rst is sampled synchronously; the first load occurs on the first rising edge with rst=0.
- Reset mid-operation discards the in-flight instruction; no partial state survives.
- With StallM=1, ALU_ResultM is held, so forwarding select 10 keeps returning the held value.
- PCSrcE is not gated by StallM or FlushM; squashing a younger instruction is the hazard/flush logic's responsibility.

Optional Feature:
- Macro: EX_MUL_EN.
- Defined: ALUControlE=111 returns the low XLEN bits of the signed×signed product of SrcA and SrcB in a single cycle (RV32M mul).
- Undefined: code 111 yields 0, and no multiplier is synthesized.

Decomposition:
- Shared package `riscv_pkg` holds:
  - ALU opcode localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_MUL.
  - Forward-select constants: FWD_RF=00, FWD_WB=01, FWD_MEM=10.
  - XLEN and REG_AW defaults.
- One sub-module, `alu`: combinational, with inputs SrcA, SrcB, ALUControl and outputs Result, Zero. The EX/MEM register and forward muxes stay in execute_stage.

Test Plan:
- Reset: assert rst mid-cycle with RegWriteM=1 → all M outputs 0 before the next edge; first edge after release loads EX values.
- Forwarding:
  - Cycle 1: add, RD1_E=5, Imm=7, ALUSrcE=1 → ALU_ResultM=12.
  - Cycle 2: ForwardA_E=10, Imm=3 → ALU_ResultM=15.
  - ForwardB_E=01 with ResultW=0xDEAD → WriteDataM=0xDEAD.
- Branch: BranchE=1, sub, A=B=0x40, PCE=0x100, Imm=0x20 → PCSrcE=1, PCTargetE=0x120. With A≠B → PCSrcE=0. JumpE=1 → PCSrcE=1 regardless of Zero.
- Compares:
  - slt A=0xFFFFFFFF, B=1 → 1.
  - sltu with same operands → 0.
  - add 0xFFFFFFFF+1 → 0 and Zero=1.
- Stall/flush:
  - StallM=1 for 3 cycles → M outputs constant.
  - FlushM=1 together with StallM=1 → RegWriteM=MemWriteM=0, RD_M=0 next cycle.
- EX_MUL_EN: op 111, A=−3, B=7 → 0xFFFFFFEB when defined; 0 when undefined.
